// File: rtl/noc_irq_injector.sv
// noc_irq_injector
// Round-robin arbitrates NUM_CH interrupt request channels, maps the linear
// tile id onto a GRID_X x GRID_Y mesh and writes a 2-flit packet (header +
// payload) into a DEPTH-flit first-word-fall-through FIFO that drains onto a
// single val/rdy NoC port.
// Optional feature: define IRQ_INJ_STATS_EN to add the stat_pkts, stat_bad
// and stat_max_occ statistics outputs.
module noc_irq_injector #(
    parameter int         NUM_CH   = 4,
    parameter int         NOC_DW   = 64,
    parameter int         DEPTH    = 16,
    parameter int         GRID_X   = 2,
    parameter int         GRID_Y   = 2,
    parameter int         TID_W    = 32,
    parameter logic [7:0] MSG_TYPE = 8'd32,
    parameter logic [3:0] FBITS    = 4'd0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        in_val,
    output logic [NUM_CH-1:0]        in_rdy,
    input  logic [NUM_CH*TID_W-1:0]  in_tile_id,
    input  logic [NUM_CH*NOC_DW-1:0] in_payload,
    output logic                     noc_out_val,
    input  logic                     noc_out_rdy,
    output logic [NOC_DW-1:0]        noc_out_data,
    output logic                     err_bad_tile,
    output logic [$clog2(DEPTH):0]   fifo_count
`ifdef IRQ_INJ_STATS_EN
    ,
    output logic [31:0]              stat_pkts,
    output logic [15:0]              stat_bad,
    output logic [$clog2(DEPTH):0]   stat_max_occ
`endif
);

    localparam int PW     = $clog2(DEPTH);
    localparam int CW     = PW + 1;
    localparam int CHW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int NTILES = GRID_X * GRID_Y;

    logic [NOC_DW-1:0] mem [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_nxt;
    logic [CHW-1:0]    rr_ptr;
    logic [CHW-1:0]    grant;
    logic [CHW-1:0]    arb_sel;
    logic              any_val;
    logic              pop;
    logic              space_ok;
    logic              accept;
    logic              push;
    logic              tid_bad;
    logic              bad_vld_p1;
    logic [TID_W-1:0]  g_tid;
    logic [NOC_DW-1:0] g_payload;
    logic [7:0]        dest_x;
    logic [7:0]        dest_y;
    logic [NOC_DW-1:0] header;

    // Round-robin search for the first valid channel starting at rr_ptr
    always_comb begin
        any_val = 1'b0;
        grant   = '0;
        arb_sel = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            arb_sel = CHW'((int'(rr_ptr) + k) % NUM_CH);
            if (!any_val && in_val[arb_sel]) begin
                any_val = 1'b1;
                grant   = arb_sel;
            end
        end
    end

    // Space check counts this cycle's pop so a full-minus-one FIFO can still take a packet
    always_comb begin
        pop      = (count_q != '0) && noc_out_rdy;
        space_ok = (DEPTH - int'(count_q) + int'(pop)) >= 2;
        accept   = rst_n && any_val && space_ok;
        in_rdy   = '0;
        if (accept) begin
            in_rdy[grant] = 1'b1;
        end
    end

    // Select the granted channel, map its tile id and build the header flit
    always_comb begin
        g_tid     = in_tile_id[int'(grant)*TID_W +: TID_W];
        g_payload = in_payload[int'(grant)*NOC_DW +: NOC_DW];
        tid_bad   = ({1'b0, g_tid} >= (TID_W+1)'(NTILES));
        dest_x    = 8'(g_tid % TID_W'(GRID_X));
        dest_y    = 8'(g_tid / TID_W'(GRID_X));
        push      = accept && !tid_bad;
        header        = '0;
        header[49:42] = dest_x;
        header[41:34] = dest_y;
        header[33:30] = FBITS;
        header[29:22] = 8'd1;
        header[21:14] = MSG_TYPE;
    end

    // Occupancy after this cycle: +2 per packet written, -1 per flit read
    always_comb begin
        count_nxt = count_q + (push ? CW'(2) : CW'(0)) - (pop ? CW'(1) : CW'(0));
    end

    // Control state: pointers, occupancy, arbiter pointer and bad-tile pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count_q    <= '0;
            rr_ptr     <= '0;
            bad_vld_p1 <= 1'b0;
        end else begin
            count_q    <= count_nxt;
            bad_vld_p1 <= accept && tid_bad;
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(2);
            end
            if (accept) begin
                rr_ptr <= CHW'((int'(grant) + 1) % NUM_CH);
            end
        end
    end

    // Flit storage: header and payload land in consecutive slots in one cycle
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr]          <= header;
            mem[wr_ptr + PW'(1)] <= g_payload;
        end
    end

    assign noc_out_val  = (count_q != '0);
    assign noc_out_data = noc_out_val ? mem[rd_ptr] : '0;
    assign err_bad_tile = bad_vld_p1;
    assign fifo_count   = count_q;

`ifdef IRQ_INJ_STATS_EN
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

    // Saturating packet counters and occupancy high-water mark
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_pkts    <= '0;
            stat_bad     <= '0;
            stat_max_occ <= '0;
        end else begin
            if (push) begin
                stat_pkts <= sat_inc32(stat_pkts);
            end
            if (accept && tid_bad) begin
                stat_bad <= sat_inc16(stat_bad);
            end
            if (count_nxt > stat_max_occ) begin
                stat_max_occ <= count_nxt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_noc_irq_injector.sv
// Bench for noc_irq_injector at default parameters (4 channels, 16-flit FIFO,
// 2x2 grid). A cycle-level reference model predicts grants, occupancy and the
// flit stream; hand-written vectors and sequences cover the corner cases.
module tb_noc_irq_injector;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   in_val = '0;
    logic [3:0]   in_rdy;
    logic [127:0] in_tile_id = '0;
    logic [255:0] in_payload = '0;
    logic         noc_out_val;
    logic         noc_out_rdy = 1'b0;
    logic [63:0]  noc_out_data;
    logic         err_bad_tile;
    logic [4:0]   fifo_count;
`ifdef IRQ_INJ_STATS_EN
    logic [31:0]  stat_pkts;
    logic [15:0]  stat_bad;
    logic [4:0]   stat_max_occ;
`endif

    int checks = 0;
    int errors = 0;

    noc_irq_injector dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_val       (in_val),
        .in_rdy       (in_rdy),
        .in_tile_id   (in_tile_id),
        .in_payload   (in_payload),
        .noc_out_val  (noc_out_val),
        .noc_out_rdy  (noc_out_rdy),
        .noc_out_data (noc_out_data),
        .err_bad_tile (err_bad_tile),
        .fifo_count   (fifo_count)
`ifdef IRQ_INJ_STATS_EN
        ,
        .stat_pkts    (stat_pkts),
        .stat_bad     (stat_bad),
        .stat_max_occ (stat_max_occ)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] exp_hdr(input logic [31:0] tid);
        logic [63:0] x;
        logic [63:0] y;
        x = 64'(tid % 32'd2);
        y = 64'(tid / 32'd2);
        return (x << 42) | (y << 34) | (64'd1 << 22) | (64'd32 << 14);
    endfunction

    // Reference model and scoreboard, evaluated mid-cycle with inputs stable
    logic [63:0] sb_q[$];
    int m_count = 0;
    int m_rr = 0;
    int m_pkts = 0;
    int m_bad = 0;
    logic m_err = 1'b0;

    always @(negedge clk) begin
        int g;
        int idx;
        logic m_pop;
        logic m_space;
        logic [3:0] exp_rdy;
        logic [31:0] tid;
        if (!rst_n) begin
            chk("rst_in_rdy", 64'(in_rdy), 64'd0);
            m_count = 0;
            m_rr    = 0;
            m_err   = 1'b0;
            sb_q.delete();
        end else begin
            chk("out_val", 64'(noc_out_val), 64'(m_count != 0));
            chk("fifo_count", 64'(fifo_count), 64'(m_count));
            chk("err_bad_tile", 64'(err_bad_tile), 64'(m_err));
            if (m_count != 0) begin
                if (sb_q.size() == 0) chk("sb_empty", 64'd1, 64'd0);
                else chk("noc_data", noc_out_data, sb_q[0]);
            end else begin
                chk("empty_data", noc_out_data, 64'd0);
            end
            m_pop = (m_count != 0) && noc_out_rdy;
            g = -1;
            for (int k = 0; k < 4; k++) begin
                idx = (m_rr + k) % 4;
                if (g < 0 && in_val[idx]) g = idx;
            end
            m_space = (16 - m_count + int'(m_pop)) >= 2;
            exp_rdy = (g >= 0 && m_space) ? (4'b0001 << g) : 4'b0000;
            chk("in_rdy", 64'(in_rdy), 64'(exp_rdy));
            if (m_pop && sb_q.size() != 0) void'(sb_q.pop_front());
            m_err = 1'b0;
            if (exp_rdy != 4'b0000) begin
                tid = in_tile_id[g*32 +: 32];
                if (tid < 32'd4) begin
                    sb_q.push_back(exp_hdr(tid));
                    sb_q.push_back(in_payload[g*64 +: 64]);
                    m_count += 2;
                    m_pkts++;
                end else begin
                    m_err = 1'b1;
                    m_bad++;
                end
                m_rr = (g + 1) % 4;
            end
            if (m_pop) m_count -= 1;
        end
    end

    typedef struct {
        logic [3:0] val;
        logic [3:0] bad;
        logic [3:0] exp_rdy;
        logic [4:0] exp_count;
        logic       exp_err;
    } vec_t;

    vec_t vecs[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] bad, input logic rdy);
        in_val      = v;
        noc_out_rdy = rdy;
        for (int c = 0; c < 4; c++) begin
            in_tile_id[c*32 +: 32] = bad[c] ? 32'(4 + c) : 32'(c);
            in_payload[c*64 +: 64] = {$urandom(), $urandom()};
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        drive(4'b0000, 4'b0000, 1'b1);
        @(negedge clk);
        while (fifo_count != 5'd0 && n < 100) begin
            tick();
            @(negedge clk);
            n++;
        end
        chk("drain_done", 64'(fifo_count), 64'd0);
        tick();
    endtask

    initial begin
        #100000;
        errors++;
        $display("FAIL timeout: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        int acc;
        vecs[0] = '{4'b1111, 4'b0000, 4'b0001, 5'd0, 1'b0};
        vecs[1] = '{4'b1111, 4'b0000, 4'b0010, 5'd2, 1'b0};
        vecs[2] = '{4'b1111, 4'b0000, 4'b0100, 5'd3, 1'b0};
        vecs[3] = '{4'b1111, 4'b0000, 4'b1000, 5'd4, 1'b0};
        vecs[4] = '{4'b0000, 4'b0000, 4'b0000, 5'd5, 1'b0};
        vecs[5] = '{4'b0100, 4'b0000, 4'b0100, 5'd4, 1'b0};
        vecs[6] = '{4'b0011, 4'b0000, 4'b0001, 5'd5, 1'b0};
        vecs[7] = '{4'b1001, 4'b0000, 4'b1000, 5'd6, 1'b0};
        vecs[8] = '{4'b0100, 4'b0100, 4'b0100, 5'd7, 1'b0};
        vecs[9] = '{4'b1000, 4'b0000, 4'b1000, 5'd6, 1'b1};

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // reset state
        drive(4'b0000, 4'b0000, 1'b0);
        @(negedge clk);
        chk("reset_val", 64'(noc_out_val), 64'd0);
        chk("reset_count", 64'(fifo_count), 64'd0);
        chk("reset_err", 64'(err_bad_tile), 64'd0);
        chk("reset_data", noc_out_data, 64'd0);
        tick();

        // round-robin vectors, downstream always ready
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].val, vecs[i].bad, 1'b1);
            @(negedge clk);
            chk($sformatf("vec%0d_rdy", i), 64'(in_rdy), 64'(vecs[i].exp_rdy));
            chk($sformatf("vec%0d_count", i), 64'(fifo_count), 64'(vecs[i].exp_count));
            chk($sformatf("vec%0d_err", i), 64'(err_bad_tile), 64'(vecs[i].exp_err));
            tick();
        end
        drain();

        // T1: single packet, header then payload
        drive(4'b0001, 4'b0000, 1'b1);
        in_tile_id[31:0] = 32'd3;
        in_payload[63:0] = 64'hA5;
        @(negedge clk);
        chk("t1_rdy", 64'(in_rdy), 64'h1);
        tick();
        drive(4'b0000, 4'b0000, 1'b1);
        @(negedge clk);
        chk("t1_hdr_val", 64'(noc_out_val), 64'd1);
        chk("t1_hdr", noc_out_data, 64'h0000_0404_0048_0000);
        chk("t1_cnt2", 64'(fifo_count), 64'd2);
        tick();
        @(negedge clk);
        chk("t1_payload", noc_out_data, 64'hA5);
        chk("t1_cnt1", 64'(fifo_count), 64'd1);
        tick();
        @(negedge clk);
        chk("t1_cnt0", 64'(fifo_count), 64'd0);
        tick();

        // T5: bad tile id on ch2
        drive(4'b0100, 4'b0000, 1'b1);
        in_tile_id[95:64] = 32'd4;
        @(negedge clk);
        chk("t5_rdy", 64'(in_rdy), 64'h4);
        tick();
        drive(4'b0000, 4'b0000, 1'b1);
        @(negedge clk);
        chk("t5_err_pulse", 64'(err_bad_tile), 64'd1);
        chk("t5_count", 64'(fifo_count), 64'd0);
        tick();
        @(negedge clk);
        chk("t5_err_clear", 64'(err_bad_tile), 64'd0);
        tick();

        // T3: fill with downstream stalled, then release
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            drive(4'b1111, 4'b0000, 1'b0);
            @(negedge clk);
            if (in_rdy != 4'b0000) acc++;
            tick();
        end
        drive(4'b1111, 4'b0000, 1'b0);
        @(negedge clk);
        chk("t3_accepts", 64'(acc), 64'd8);
        chk("t3_full_count", 64'(fifo_count), 64'd16);
        chk("t3_full_rdy", 64'(in_rdy), 64'd0);
        tick();
        drain();

        // T4: count 15, boundary without and with a simultaneous pop
        for (int i = 0; i < 8; i++) begin
            drive(4'b1111, 4'b0000, 1'b0);
            @(negedge clk);
            tick();
        end
        drive(4'b0000, 4'b0000, 1'b1);
        @(negedge clk);
        tick();
        drive(4'b0001, 4'b0000, 1'b0);
        @(negedge clk);
        chk("t4_count15", 64'(fifo_count), 64'd15);
        chk("t4_nopop_rdy", 64'(in_rdy), 64'd0);
        tick();
        drive(4'b0001, 4'b0000, 1'b1);
        @(negedge clk);
        chk("t4_pop_rdy", 64'(in_rdy), 64'h1);
        tick();
        drive(4'b0000, 4'b0000, 1'b0);
        @(negedge clk);
        chk("t4_count16", 64'(fifo_count), 64'd16);
        tick();
        drain();

`ifdef IRQ_INJ_STATS_EN
        @(negedge clk);
        chk("stat_pkts", 64'(stat_pkts), 64'(m_pkts));
        chk("stat_bad", 64'(stat_bad), 64'(m_bad));
        chk("stat_max_occ", 64'(stat_max_occ), 64'd16);
        tick();
`endif

        // T6: reset with 6 flits queued and rr_ptr away from zero
        for (int i = 0; i < 3; i++) begin
            drive(4'b0110, 4'b0000, 1'b0);
            @(negedge clk);
            tick();
        end
        drive(4'b0000, 4'b0000, 1'b0);
        @(negedge clk);
        chk("t6_count6", 64'(fifo_count), 64'd6);
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        drive(4'b1111, 4'b0000, 1'b1);
        @(negedge clk);
        chk("t6_val", 64'(noc_out_val), 64'd0);
        chk("t6_count", 64'(fifo_count), 64'd0);
        chk("t6_rr_reset", 64'(in_rdy), 64'h1);
        tick();
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
